// File: rtl/ramp_control_pkg.sv
// ramp_control_pkg: shared state enum, ramp mode encodings and reset constants for ramp_control
package ramp_control_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_REPEAT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam state_t     RST_STATE    = IDLE;
  localparam logic [1:0] RST_MD       = MODE_ONESHOT;
  localparam int         RST_STP      = 1;
endpackage

// File: rtl/ramp_prescaler.sv
// ramp_prescaler: divides clk into a one-cycle tick every PRESCALE cycles
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the tick phase (counter back to 0)
//   hold     : freeze the counter and suppress tick
//   tick     : high in the last cycle of each PRESCALE-cycle period
module ramp_prescaler
  import ramp_control_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : hold ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tick = (cnt_q == LAST) && !hold;
endmodule

// File: rtl/ramp_control.sv
// ramp_control: programmable up / repeat / bounce ramp generator with registered outputs
//   clk, rst : clock, synchronous active-high reset
//   ini      : load ent/step/mode and restart the ramp (wins over pause and counting)
//   ent      : target value; step : increment per tick (0 acts as 1); mode : ramp mode
//   pause    : freezes sal and the tick counter
//   sal      : current ramp value; busy : in RUN; done : one-cycle pulse on reaching target
//              (or on returning to 0 in bounce mode)
//   Build option: define RAMP_CONTROL_PRESCALE_EN to tick once every PRESCALE cycles
//   instead of every cycle.
module ramp_control
  import ramp_control_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ini,
  input  logic [WIDTH-1:0]  ent,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic              pause,
  output logic [WIDTH-1:0]  sal,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sal_q, sal_d, tgt_q, tgt_d;
  logic [STEP_W-1:0] stp_q, stp_d;
  logic [1:0] md_q, md_d;
  logic dir_q, dir_d, done_q, done_d, tick;
  logic [WIDTH:0] up_sum;
  logic [WIDTH-1:0] stp_w, up_val, dn_val;
  logic at_top, going_dn;
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end
`ifdef RAMP_CONTROL_PRESCALE_EN
  ramp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (ini),
    .hold(pause),
    .tick(tick)
  );
`else
  assign tick = 1'b1;
`endif
  assign stp_w  = WIDTH'(stp_q);
  // One extra bit so sal+stp cannot wrap before being clamped to the target
  assign up_sum = {1'b0, sal_q} + {1'b0, stp_w};
  assign up_val = up_sum >= {1'b0, tgt_q} ? tgt_q : up_sum[WIDTH-1:0];
  assign dn_val = sal_q > stp_w ? sal_q - stp_w : '0;
  assign at_top = sal_q == tgt_q;
  // Bounce turns down when it sits on the target and back up once it sits on 0
  assign going_dn = dir_q ? sal_q != '0 : at_top;
  always_comb begin
    state_d = state_q;
    sal_d   = sal_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    md_d    = md_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (ini) begin
      tgt_d   = ent;
      stp_d   = step == '0 ? STEP_W'(1) : step;
      md_d    = mode;
      sal_d   = '0;
      dir_d   = 1'b0;
      state_d = ent == '0 ? HOLD : RUN;
      done_d  = ent == '0;
    end else if (state_q == RUN && tick && !pause) begin
      if (md_q == MODE_BOUNCE) begin
        sal_d  = going_dn ? dn_val : up_val;
        dir_d  = going_dn;
        done_d = going_dn ? dn_val == '0 : up_val == tgt_q;
      end else if (at_top) begin
        sal_d   = md_q == MODE_REPEAT ? '0 : sal_q;
        state_d = md_q == MODE_REPEAT ? RUN : HOLD;
      end else begin
        sal_d  = up_val;
        done_d = up_val == tgt_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      sal_q   <= '0;
      tgt_q   <= '0;
      stp_q   <= STEP_W'(RST_STP);
      md_q    <= RST_MD;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sal_q   <= sal_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      md_q    <= md_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
  assign sal  = sal_q;
  assign busy = state_q == RUN;
  assign done = done_q;
endmodule

// File: tb/tb_ramp_control.sv
// tb_ramp_control: directed vector tables plus randomized run against a trajectory model
module tb_ramp_control;
  localparam int W = 8, SW = 4, P = 4;
  logic clk = 1'b0;
  logic rst = 1'b0, ini = 1'b0, pause = 1'b0;
  logic [W-1:0] ent = '0;
  logic [SW-1:0] step = '0;
  logic [1:0] mode = '0;
  logic [W-1:0] sal;
  logic busy, done;
  always #5 clk = ~clk;
  ramp_control #(.WIDTH(W), .STEP_W(SW), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .ini(ini), .ent(ent), .step(step), .mode(mode),
    .pause(pause), .sal(sal), .busy(busy), .done(done)
  );
  int n_vec = 0, n_err = 0;
  // Model: on ini the whole trajectory (one period for repeat/bounce) is listed;
  // k indexes it and advances once per effective tick.
  int lst[$] = '{0};
  int k = 0, m_tgt = 0, m_md = 0, pc = 0;
  bit m_run = 0, m_done = 0;
  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic m_start(int t, int s, int md);
    int v = 0;
    if (s == 0) s = 1;
    lst = '{0};
    while (v < t) begin
      v = v + s > t ? t : v + s;
      lst.push_back(v);
    end
    if (md == 2)
      while (v > 0) begin
        v = v > s ? v - s : 0;
        if (v > 0) lst.push_back(v);
      end
  endtask
  task automatic m_clock();
    bit tk;
    m_done = 0;
    if (rst) begin
      lst = '{0};
      k = 0;
      m_run = 0;
    end else if (ini) begin
      m_start(int'(ent), int'(step), int'(mode));
      k = 0;
      pc = 0;
      m_tgt = int'(ent);
      m_md = int'(mode);
      m_run = ent != 0;
      m_done = ent == 0;
    end else if (m_run && !pause) begin
      pc++;
`ifdef RAMP_CONTROL_PRESCALE_EN
      tk = pc % P == 0;
`else
      tk = 1;
`endif
      if (tk) begin
        if (m_md == 1 || m_md == 2) begin
          k = (k + 1) % lst.size();
          m_done = lst[k] == m_tgt || (m_md == 2 && lst[k] == 0);
        end else if (k == lst.size() - 1) m_run = 0;
        else begin
          k++;
          m_done = k == lst.size() - 1;
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    m_clock();
    #1;
  endtask
  task automatic chk_model(string tag);
    chk({tag, " sal(model)"}, int'(sal), lst[k]);
    chk({tag, " busy(model)"}, int'(busy), int'(m_run));
    chk({tag, " done(model)"}, int'(done), int'(m_done));
  endtask
  typedef struct {
    bit r, i;
    int e, s, m;
    bit p;
    int xs;
    bit xb, xd;
  } vec_t;
  vec_t tbl[$];
  task automatic add(bit r, bit i, int e, int s, int m, bit p, int xs, bit xb, bit xd);
    tbl.push_back('{r, i, e, s, m, p, xs, xb, xd});
  endtask
  task automatic n(int xs, bit xb, bit xd);
    add(0, 0, 0, 0, 0, 0, xs, xb, xd);
  endtask
  task automatic ps(int xs, bit xb, bit xd);
    add(0, 0, 0, 0, 0, 1, xs, xb, xd);
  endtask
  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RAMP_CONTROL_PRESCALE_EN
    add(0, 1, 2, 1, 0, 0, 0, 1, 0);
    n(0, 1, 0); n(0, 1, 0); n(0, 1, 0); n(1, 1, 0);
    n(1, 1, 0); n(1, 1, 0); n(1, 1, 0); n(2, 1, 1);
    n(2, 1, 0); n(2, 1, 0); n(2, 1, 0); n(2, 0, 0);
    add(0, 1, 3, 1, 0, 0, 0, 1, 0); n(0, 1, 0); n(0, 1, 0);
    add(0, 1, 3, 1, 0, 0, 0, 1, 0);
    n(0, 1, 0); n(0, 1, 0); n(0, 1, 0); n(1, 1, 0);
    add(0, 1, 2, 1, 0, 0, 0, 1, 0); n(0, 1, 0);
    ps(0, 1, 0); ps(0, 1, 0); ps(0, 1, 0);
    n(0, 1, 0); n(0, 1, 0); n(1, 1, 0);
`else
    add(0, 1, 5, 1, 0, 0, 0, 1, 0);
    n(1, 1, 0); n(2, 1, 0); n(3, 1, 0); n(4, 1, 0); n(5, 1, 1); n(5, 0, 0); n(5, 0, 0);
    add(0, 1, 10, 4, 1, 0, 0, 1, 0);
    n(4, 1, 0); n(8, 1, 0); n(10, 1, 1); n(0, 1, 0); n(4, 1, 0); n(8, 1, 0); n(10, 1, 1); n(0, 1, 0);
    add(0, 1, 6, 4, 2, 0, 0, 1, 0);
    n(4, 1, 0); n(6, 1, 1); n(2, 1, 0); n(0, 1, 1); n(4, 1, 0); n(6, 1, 1); n(2, 1, 0);
    add(0, 1, 0, 3, 0, 0, 0, 0, 1); n(0, 0, 0); n(0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 1, 0); n(1, 1, 0); n(2, 1, 1); n(2, 0, 0);
    add(0, 1, 3, 2, 3, 0, 0, 1, 0); n(2, 1, 0); n(3, 1, 1); n(3, 0, 0);
    add(0, 1, 10, 1, 0, 0, 0, 1, 0); n(1, 1, 0); n(2, 1, 0);
    add(1, 1, 7, 2, 1, 0, 0, 0, 0); n(0, 0, 0);
    add(0, 1, 20, 3, 0, 0, 0, 1, 0); n(3, 1, 0); n(6, 1, 0);
    ps(6, 1, 0); ps(6, 1, 0); ps(6, 1, 0); n(9, 1, 0); n(12, 1, 0);
    add(0, 1, 9, 2, 1, 1, 0, 1, 0); ps(0, 1, 0); n(2, 1, 0);
`endif
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < tbl.size(); j++) begin
      rst = tbl[j].r;
      ini = tbl[j].i;
      ent = W'(tbl[j].e);
      step = SW'(tbl[j].s);
      mode = 2'(tbl[j].m);
      pause = tbl[j].p;
      cyc();
      chk($sformatf("vec%0d sal", j), int'(sal), tbl[j].xs);
      chk($sformatf("vec%0d busy", j), int'(busy), int'(tbl[j].xb));
      chk($sformatf("vec%0d done", j), int'(done), int'(tbl[j].xd));
      chk_model($sformatf("vec%0d", j));
    end
`ifndef RAMP_CONTROL_PRESCALE_EN
    // 252+7 overflows 8 bits; sal must clamp to 255 rather than wrap
    rst = 0; ini = 1; ent = 8'd255; step = 4'd7; mode = 2'd0; pause = 0;
    cyc();
    ini = 0;
    for (int j = 1; j <= 38; j++) begin
      cyc();
      chk($sformatf("sat%0d sal", j), int'(sal), j * 7 > 255 ? 255 : j * 7);
      chk($sformatf("sat%0d busy", j), int'(busy), int'(j <= 37));
      chk($sformatf("sat%0d done", j), int'(done), int'(j == 37));
    end
`endif
    for (int j = 0; j < 600; j++) begin
      rst = $urandom_range(0, 99) == 0;
      ini = $urandom_range(0, 14) == 0;
      ent = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
      step = SW'($urandom_range(0, 15));
      mode = 2'($urandom_range(0, 3));
      pause = $urandom_range(0, 4) == 0;
      cyc();
      chk_model($sformatf("rnd%0d", j));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
